// File: rtl/row_chunk_scheduler.sv
// rtl/row_chunk_scheduler.sv - ping-pong row buffer that streams each captured row as tagged 16-bit chunks
module row_chunk_scheduler #(
    parameter int ROW_BITS       = 480,
    parameter int CHUNK_BITS     = 16,
    parameter int ROWS_PER_FRAME = 480,
    parameter int ROW_W          = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ROW_BITS-1:0]   row_data,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic                  frame_start,
    output logic [CHUNK_BITS-1:0] chunk_data,
    output logic                  chunk_valid,
    input  logic                  chunk_ready,
    output logic [ROW_W-1:0]      chunk_row,
    output logic [4:0]            chunk_idx,
    output logic                  chunk_last,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int               NCHUNK   = ROW_BITS / CHUNK_BITS;
    localparam logic [4:0]       LAST_IDX = 5'(NCHUNK - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_FRAME - 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_next;

    logic [ROW_BITS-1:0] row_buf [2];
    logic [ROW_W-1:0]    row_tag [2];
    logic [1:0]          cnt, cnt_next;
    logic                wr_sel, rd_sel;
    logic [ROW_W-1:0]    row_cnt;
    logic [4:0]          idx;
    logic                frame_done_q;
    logic                streaming, accept, fire, release_buf;

    assign streaming   = (state == STREAM) && !reset;
    assign row_ready   = !reset && (cnt != 2'd2);
    assign accept      = row_valid && row_ready;
    assign fire        = streaming && chunk_ready;
    assign release_buf = fire && (idx == LAST_IDX);

    // Occupancy counts the buffer being streamed until its last beat leaves.
    always_comb begin
        cnt_next = cnt;
        if (accept && !release_buf)
            cnt_next = cnt + 2'd1;
        else if (!accept && release_buf)
            cnt_next = cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A row accepted on the releasing edge keeps STREAM, so rows run back-to-back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cnt != 2'd0) state_next = STREAM;
            STREAM:  if (release_buf && cnt_next == 2'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= 2'd0;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            row_cnt      <= '0;
            idx          <= 5'd0;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            frame_done_q <= release_buf && (row_tag[rd_sel] == LAST_ROW);
            if (accept) begin
                wr_sel <= !wr_sel;
                if (frame_start)
                    row_cnt <= ROW_W'(1);
                else if (row_cnt == LAST_ROW)
                    row_cnt <= '0;
                else
                    row_cnt <= row_cnt + ROW_W'(1);
            end else if (frame_start) begin
                row_cnt <= '0;
            end
            if (release_buf) begin
                rd_sel <= !rd_sel;
                idx    <= 5'd0;
            end else if (fire) begin
                idx <= idx + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[wr_sel] <= row_data;
            row_tag[wr_sel] <= frame_start ? '0 : row_cnt;
        end
    end

    assign chunk_valid = streaming;
    assign chunk_data  = streaming ? row_buf[rd_sel][int'(idx)*CHUNK_BITS +: CHUNK_BITS] : '0;
    assign chunk_row   = streaming ? row_tag[rd_sel] : '0;
    assign chunk_idx   = streaming ? idx : 5'd0;
    assign chunk_last  = streaming && (idx == LAST_IDX);
    assign frame_done  = frame_done_q && !reset;
    assign busy        = !reset && ((state == STREAM) || (cnt != 2'd0));
endmodule

// File: tb/tb_row_chunk_scheduler.sv
// tb/tb_row_chunk_scheduler.sv - self-checking bench for row_chunk_scheduler
module tb_row_chunk_scheduler;
    localparam int ROW_BITS = 480;
    localparam int CB       = 16;
    localparam int RPF      = 480;
    localparam int ROW_W    = 10;
    localparam int NCHUNK   = 30;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [ROW_BITS-1:0] row_data = '0;
    logic                row_valid = 1'b0;
    logic                row_ready;
    logic                frame_start = 1'b0;
    logic [CB-1:0]       chunk_data;
    logic                chunk_valid;
    logic                chunk_ready = 1'b0;
    logic [ROW_W-1:0]    chunk_row;
    logic [4:0]          chunk_idx;
    logic                chunk_last;
    logic                frame_done;
    logic                busy;

    row_chunk_scheduler dut (
        .clk(clk), .reset(reset), .row_data(row_data), .row_valid(row_valid),
        .row_ready(row_ready), .frame_start(frame_start), .chunk_data(chunk_data),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_row(chunk_row),
        .chunk_idx(chunk_idx), .chunk_last(chunk_last), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROW_BITS-1:0] data;
        logic [ROW_W-1:0]    tag;
    } row_t;

    typedef struct {
        bit         cr;
        bit         exp_valid;
        logic [4:0] exp_idx;
        logic [15:0] exp_data;
    } t1_vec_t;

    row_t pend[$];
    bit   m_valid;
    bit   m_fd;
    int   m_idx;
    int   m_rc;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   fd_seen = 0;
    bit   acc_flag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] rand_row();
        logic [ROW_BITS-1:0] r;
        for (int k = 0; k < ROW_BITS / 32; k++)
            r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        if (reset) begin
            chk("rst_row_ready", 64'(row_ready), 64'(0));
            chk("rst_chunk_valid", 64'(chunk_valid), 64'(0));
            chk("rst_chunk_data", 64'(chunk_data), 64'(0));
            chk("rst_chunk_row", 64'(chunk_row), 64'(0));
            chk("rst_chunk_idx", 64'(chunk_idx), 64'(0));
            chk("rst_chunk_last", 64'(chunk_last), 64'(0));
            chk("rst_frame_done", 64'(frame_done), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            return;
        end
        chk("row_ready", 64'(row_ready), 64'(pend.size() < 2));
        chk("chunk_valid", 64'(chunk_valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(m_valid || pend.size() > 0));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        if (m_valid) begin
            chk("chunk_data", 64'(chunk_data), 64'(pend[0].data[m_idx*CB +: CB]));
            chk("chunk_idx", 64'(chunk_idx), 64'(m_idx));
            chk("chunk_row", 64'(chunk_row), 64'(pend[0].tag));
            chk("chunk_last", 64'(chunk_last), 64'(m_idx == NCHUNK - 1));
        end
    endtask

    // One clock: drive inputs, advance the reference model across the edge, then compare.
    task automatic step(input bit rv, input logic [ROW_BITS-1:0] rd, input bit fs,
                        input bit cr, input bit rst, output bit acc);
        row_t r;
        bit   prev_valid;
        int   size_after_pop;
        reset = rst; row_valid = rv; row_data = rd; frame_start = fs; chunk_ready = cr;
        acc = 1'b0;
        if (rst) begin
            pend.delete();
            m_valid = 1'b0; m_idx = 0; m_rc = 0; m_fd = 1'b0;
        end else begin
            acc = rv && (pend.size() < 2);
            m_fd = 1'b0;
            prev_valid = m_valid;
            if (m_valid && cr) begin
                if (m_idx == NCHUNK - 1) begin
                    m_fd = (pend[0].tag == ROW_W'(RPF - 1));
                    void'(pend.pop_front());
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            size_after_pop = pend.size();
            if (acc) begin
                r.data = rd;
                r.tag  = fs ? '0 : ROW_W'(m_rc);
                pend.push_back(r);
                m_rc = fs ? 1 : ((m_rc == RPF - 1) ? 0 : m_rc + 1);
            end else if (fs) begin
                m_rc = 0;
            end
            m_valid = (size_after_pop > 0) || (acc && prev_valid);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (frame_done) fd_seen++;
    endtask

    task automatic do_reset();
        bit a;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    // mode 0: always ready, 1: ready toggles each cycle, 2: ready 3/4 of the time
    task automatic run_rows(input int n, input bit fs_first, input int mode);
        int acc_n;
        int budget;
        bit a;
        bit cr;
        acc_n  = 0;
        budget = n * 70 + 200;
        while ((acc_n < n || m_valid || pend.size() > 0) && budget > 0) begin
            if (mode == 0)      cr = 1'b1;
            else if (mode == 1) cr = cyc[0];
            else                cr = ($urandom_range(0, 3) != 0);
            step(acc_n < n, rand_row(), fs_first && (acc_n == 0), cr, 1'b0, a);
            if (a) acc_n++;
            budget--;
        end
        chk("run_rows_budget", 64'(budget > 0), 64'(1));
        chk("run_rows_drained", 64'(busy), 64'(0));
    endtask

    initial begin
        t1_vec_t             t1 [6];
        logic [ROW_BITS-1:0] t1_row;
        int                  t5_budget;

        t1[0] = '{cr: 1'b1, exp_valid: 1'b0, exp_idx: 5'd0, exp_data: 16'h0000};
        t1[1] = '{cr: 1'b1, exp_valid: 1'b1, exp_idx: 5'd0, exp_data: 16'hFFFF};
        t1[2] = '{cr: 1'b0, exp_valid: 1'b1, exp_idx: 5'd0, exp_data: 16'hFFFF};
        t1[3] = '{cr: 1'b1, exp_valid: 1'b1, exp_idx: 5'd1, exp_data: 16'h0000};
        t1[4] = '{cr: 1'b1, exp_valid: 1'b1, exp_idx: 5'd2, exp_data: 16'h0001};
        t1[5] = '{cr: 1'b1, exp_valid: 1'b1, exp_idx: 5'd3, exp_data: 16'h0000};
        t1_row = '0;
        t1_row[47:0] = 48'h0001_0000_FFFF;

        // T1: single row, latency, LSB-first chunk order, then back to idle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(i == 0, t1_row, 1'b0, t1[i].cr, 1'b0, acc_flag);
            chk("t1_valid", 64'(chunk_valid), 64'(t1[i].exp_valid));
            if (t1[i].exp_valid) begin
                chk("t1_idx", 64'(chunk_idx), 64'(t1[i].exp_idx));
                chk("t1_data", 64'(chunk_data), 64'(t1[i].exp_data));
                chk("t1_row", 64'(chunk_row), 64'(0));
            end
        end
        for (int i = 0; i < NCHUNK - 3; i++)
            step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc_flag);
        chk("t1_idle_valid", 64'(chunk_valid), 64'(0));
        chk("t1_idle_busy", 64'(busy), 64'(0));

        // T2: three rows back-to-back, no bubble between rows
        run_rows(3, 1'b0, 0);

        // T3: consumer toggles ready every cycle
        run_rows(3, 1'b0, 1);

        // T4: a full frame plus one row, frame_done once
        do_reset();
        fd_seen = 0;
        run_rows(RPF + 1, 1'b1, 0);
        chk("t4_frame_done_pulses", 64'(fd_seen), 64'(1));

        // T5: reset mid-row with the second buffer full
        do_reset();
        t5_budget = 400;
        while (!(pend.size() == 2 && pend[0].tag == ROW_W'(5) && m_idx == 12) && t5_budget > 0) begin
            step(1'b1, rand_row(), 1'b0, 1'b1, 1'b0, acc_flag);
            t5_budget--;
        end
        chk("t5_reached_row5_idx12", 64'(t5_budget > 0), 64'(1));
        step(1'b1, rand_row(), 1'b0, 1'b1, 1'b1, acc_flag);
        run_rows(1, 1'b0, 0);

        // T6: frame_start coincident with an accept at counter 37
        do_reset();
        run_rows(37, 1'b0, 0);
        run_rows(2, 1'b1, 0);

        // Randomized traffic with sporadic frame_start and reset
        do_reset();
        for (int i = 0; i < 4000; i++)
            step(1'($urandom_range(0, 1)), rand_row(), $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0, acc_flag);
        run_rows(2, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
